// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
// Scans a 4x4 active-low membrane keypad one row at a time. It synchronizes
// and debounces the column lines, decodes the pressed key into a 4-bit code,
// and emits one key_valid pulse for each debounced press.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   matricial_col  keypad columns, active-low, bit i = column i
//   matricial_lin  keypad rows, active-low one-hot drive, bit i = row i
//   key_code       code of the last accepted key, held until the next one
//   key_valid      one-cycle pulse, key_code is valid in the same cycle
//   key_held       high from acceptance until the release is debounced
module keypad_matrix_scanner #(
  parameter int unsigned SCAN_CYCLES     = 50000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] matricial_col,
  output logic [3:0] matricial_lin,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned SCAN_W = $clog2(SCAN_CYCLES + 1);
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_RELEASE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_col_meta;
  logic [3:0]        r_col_s;
  logic [1:0]        r_row;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [DEB_W-1:0]  r_stab_cnt;
  logic [3:0]        r_col_pat;
  logic [1:0]        r_col_idx;
  logic [3:0]        r_lin;
  logic [3:0]        r_key_code;
  logic              r_key_valid;
  logic              r_key_held;

  state_t            w_state_nxt;
  logic [1:0]        w_row_nxt;
  logic [SCAN_W-1:0] w_scan_cnt_nxt;
  logic [DEB_W-1:0]  w_stab_cnt_nxt;
  logic [3:0]        w_col_pat_nxt;
  logic [1:0]        w_col_idx_nxt;
  logic [3:0]        w_lin_nxt;
  logic [3:0]        w_key_code_nxt;
  logic              w_key_valid_nxt;
  logic              w_key_held_nxt;
  logic              w_one_zero;
  logic [1:0]        w_zero_idx;

  // (row, column) to key code; row 3 carries *, 0, #, D
  function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Exactly one active-low column and its index
  always_comb begin
    w_one_zero = 1'b1;
    w_zero_idx = 2'd0;
    case (r_col_s)
      4'b1110: w_zero_idx = 2'd0;
      4'b1101: w_zero_idx = 2'd1;
      4'b1011: w_zero_idx = 2'd2;
      4'b0111: w_zero_idx = 2'd3;
      default: w_one_zero = 1'b0;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_row_nxt       = r_row;
    w_scan_cnt_nxt  = r_scan_cnt;
    w_stab_cnt_nxt  = r_stab_cnt;
    w_col_pat_nxt   = r_col_pat;
    w_col_idx_nxt   = r_col_idx;
    w_key_code_nxt  = r_key_code;
    w_key_valid_nxt = 1'b0;
    w_key_held_nxt  = r_key_held;

    case (r_state)
      S_SCAN: begin
        if (r_scan_cnt == SCAN_LAST) begin
          w_scan_cnt_nxt = '0;
          if (r_col_s == 4'b1111) begin
            w_row_nxt = r_row + 2'd1;
          end else if (w_one_zero) begin
            w_col_pat_nxt  = r_col_s;
            w_col_idx_nxt  = w_zero_idx;
            w_stab_cnt_nxt = '0;
            w_state_nxt    = S_DEBOUNCE;
          end else begin
            // Multi-key press: wait for a full release without reporting
            w_stab_cnt_nxt = '0;
            w_state_nxt    = S_RELEASE;
          end
        end else begin
          w_scan_cnt_nxt = r_scan_cnt + SCAN_W'(1);
        end
      end

      S_DEBOUNCE: begin
        if (r_col_s == r_col_pat) begin
          if (r_stab_cnt == DEB_LAST) begin
            w_key_code_nxt  = decode_key(r_row, r_col_idx);
            w_key_valid_nxt = 1'b1;
            w_key_held_nxt  = 1'b1;
            w_stab_cnt_nxt  = '0;
            w_state_nxt     = S_RELEASE;
          end else begin
            w_stab_cnt_nxt = r_stab_cnt + DEB_W'(1);
          end
        end else begin
          w_row_nxt      = r_row + 2'd1;
          w_scan_cnt_nxt = '0;
          w_state_nxt    = S_SCAN;
        end
      end

      S_RELEASE: begin
        if (r_col_s == 4'b1111) begin
          if (r_stab_cnt == DEB_LAST) begin
            w_key_held_nxt = 1'b0;
            w_row_nxt      = r_row + 2'd1;
            w_scan_cnt_nxt = '0;
            w_stab_cnt_nxt = '0;
            w_state_nxt    = S_SCAN;
          end else begin
            w_stab_cnt_nxt = r_stab_cnt + DEB_W'(1);
          end
        end else begin
          w_stab_cnt_nxt = '0;
        end
      end

      default: begin
        w_state_nxt    = S_SCAN;
        w_scan_cnt_nxt = '0;
        w_stab_cnt_nxt = '0;
      end
    endcase

    // Row drive follows the next row directly so there is never an all-high gap
    w_lin_nxt = ~(4'(1) << w_row_nxt);
  end

  // State and data registers, including the two-flop column synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_SCAN;
      r_col_meta  <= 4'b1111;
      r_col_s     <= 4'b1111;
      r_row       <= 2'd0;
      r_scan_cnt  <= '0;
      r_stab_cnt  <= '0;
      r_col_pat   <= 4'b1111;
      r_col_idx   <= 2'd0;
      r_lin       <= 4'b1110;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col_meta  <= matricial_col;
      r_col_s     <= r_col_meta;
      r_row       <= w_row_nxt;
      r_scan_cnt  <= w_scan_cnt_nxt;
      r_stab_cnt  <= w_stab_cnt_nxt;
      r_col_pat   <= w_col_pat_nxt;
      r_col_idx   <= w_col_idx_nxt;
      r_lin       <= w_lin_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_held  <= w_key_held_nxt;
    end
  end

  assign matricial_lin = r_lin;
  assign key_code      = r_key_code;
  assign key_valid     = r_key_valid;
  assign key_held      = r_key_held;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner
// Directed bench for keypad_matrix_scanner with SCAN_CYCLES=4 and
// DEBOUNCE_CYCLES=8. A keypad model shorts each pressed key's row to its
// column. Key index = row*4 + col.
module tb_keypad_matrix_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] keys;
  logic [3:0]  col;
  logic [3:0]  lin;
  logic [3:0]  code;
  logic        valid;
  logic        held;

  int checks  = 0;
  int errors  = 0;
  int n_pulse = 0;

  always #5 clk = ~clk;

  keypad_matrix_scanner #(
    .SCAN_CYCLES     (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .matricial_col (col),
    .matricial_lin (lin),
    .key_code      (code),
    .key_valid     (valid),
    .key_held      (held)
  );

  // Keypad: a pressed key pulls its column low while its row is driven low
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && !lin[r]) col[c] = 1'b0;
  end

  always @(negedge clk) if (valid === 1'b1) n_pulse++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a key_valid pulse and check its code and key_held
  task automatic wait_pulse(input string tag, input logic [3:0] exp_code);
    int k = 0;
    while (valid !== 1'b1 && k < 80) begin
      step();
      k++;
    end
    chk({tag, " pulse"}, 32'(valid), 32'd1);
    chk({tag, " code"}, 32'(code), 32'(exp_code));
    chk({tag, " held"}, 32'(held), 32'd1);
  endtask

  // Wait (bounded) for key_held to fall, then let scanning resume
  task automatic wait_release(input string tag);
    int k = 0;
    while (held !== 1'b0 && k < 80) begin
      step();
      k++;
    end
    chk({tag, " released"}, 32'(held), 32'd0);
    repeat (4) step();
  endtask

  logic [3:0] exp_map [16];
  logic [3:0] exp_lin;
  int p0;

  initial begin
    exp_map = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    rst  = 1'b1;
    keys = 16'h0000;
    repeat (3) step();
    chk("init lin", 32'(lin), 32'h E);
    chk("init valid", 32'(valid), 32'd0);
    chk("init held", 32'(held), 32'd0);
    chk("init code", 32'(code), 32'd0);
    rst = 1'b0;

    // Press "5", then reset while it is held
    keys = 16'h0020;
    wait_pulse("key5", 4'h5);
    step();
    p0  = n_pulse;
    rst = 1'b1;
    step();
    chk("rst lin", 32'(lin), 32'hE);
    chk("rst valid", 32'(valid), 32'd0);
    chk("rst held", 32'(held), 32'd0);
    chk("rst code", 32'(code), 32'd0);
    step();
    step();
    chk("rst3 held", 32'(held), 32'd0);
    keys = 16'h0000;
    rst  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp_lin = ~(4'(1) << ((i / 4) % 4));
      chk("row cycle", 32'(lin), 32'(exp_lin));
      step();
    end
    chk("no pulse after rst", 32'(n_pulse - p0), 32'd0);

    // Single press "7", held 40 cycles, exact release timing
    p0   = n_pulse;
    keys = 16'h0100;
    wait_pulse("key7", 4'h7);
    repeat (30) step();
    chk("key7 count", 32'(n_pulse - p0), 32'd1);
    chk("key7 still held", 32'(held), 32'd1);
    keys = 16'h0000;
    repeat (9) step();
    chk("key7 held before debounce", 32'(held), 32'd1);
    step();
    chk("key7 held after debounce", 32'(held), 32'd0);
    repeat (20) step();
    chk("key7 no repeat", 32'(n_pulse - p0), 32'd1);

    // Bouncing "#", then stable
    p0 = n_pulse;
    for (int t = 0; t < 10; t++) begin
      keys = (t % 2 == 0) ? 16'h4000 : 16'h0000;
      repeat (3) step();
    end
    chk("bounce no pulse", 32'(n_pulse - p0), 32'd0);
    chk("bounce not held", 32'(held), 32'd0);
    keys = 16'h4000;
    wait_pulse("hash", 4'hF);
    step();
    keys = 16'h0000;
    wait_release("hash");
    chk("hash count", 32'(n_pulse - p0), 32'd1);

    // All 16 keys in order
    for (int i = 0; i < 16; i++) begin
      p0   = n_pulse;
      keys = 16'(1) << i;
      wait_pulse("map", exp_map[i]);
      step();
      keys = 16'h0000;
      wait_release("map");
      chk("map count", 32'(n_pulse - p0), 32'd1);
    end

    // Multi-key "1" + "2": rejected, scanning parked on row 0 until release
    p0   = n_pulse;
    keys = 16'h0003;
    repeat (60) step();
    chk("multi no pulse", 32'(n_pulse - p0), 32'd0);
    chk("multi not held", 32'(held), 32'd0);
    chk("multi row parked", 32'(lin), 32'hE);
    keys = 16'h0000;
    repeat (9) step();
    chk("multi parked before debounce", 32'(lin), 32'hE);
    step();
    chk("multi resume row1", 32'(lin), 32'hD);
    repeat (10) step();
    chk("multi still no pulse", 32'(n_pulse - p0), 32'd0);

    // Rollover: hold "A", add "0", release both, then "0" alone
    p0   = n_pulse;
    keys = 16'h0008;
    wait_pulse("keyA", 4'hA);
    step();
    keys = 16'h2008;
    repeat (30) step();
    chk("rollover count", 32'(n_pulse - p0), 32'd1);
    chk("rollover held", 32'(held), 32'd1);
    keys = 16'h0000;
    wait_release("rollover");
    chk("rollover after release", 32'(n_pulse - p0), 32'd1);
    keys = 16'h2000;
    wait_pulse("key0", 4'h0);
    step();
    keys = 16'h0000;
    wait_release("key0");
    chk("key0 count", 32'(n_pulse - p0), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
